// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment.
// The slave side is the sequencer; the master side supplies qualifiers and observes the reset set.
interface reset_sequencer_if;
    logic       hard_resetn;
    logic       soft_reset_req;
    logic       periph_reset;
    logic       cpu_reset;
    logic       cpu_resetn;
    logic       seq_done;
    logic [7:0] lock_loss_count;
    logic [2:0] state_dbg;

    modport master (
        output hard_resetn,
        output soft_reset_req,
        input  periph_reset,
        input  cpu_reset,
        input  cpu_resetn,
        input  seq_done,
        input  lock_loss_count,
        input  state_dbg
    );

    modport slave (
        input  hard_resetn,
        input  soft_reset_req,
        output periph_reset,
        output cpu_reset,
        output cpu_resetn,
        output seq_done,
        output lock_loss_count,
        output state_dbg
    );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: synchronise the lock/calibration qualifier, wait for it to be stable,
// free peripherals, then the CPU; supports CPU-only soft resets and counts lock losses.
module reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int PERIPH_TO_CPU = 16,
    parameter int SOFT_CYCLES   = 32
) (
    input logic              clk,
    input logic              reset,
    reset_sequencer_if.slave rs
);
    localparam int MAX_A = (STABLE_CYCLES > PERIPH_TO_CPU) ? STABLE_CYCLES : PERIPH_TO_CPU;
    localparam int MAX_P = (MAX_A > SOFT_CYCLES) ? MAX_A : SOFT_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [2:0] HOLD   = 3'd0;
    localparam logic [2:0] STABLE = 3'd1;
    localparam logic [2:0] PERIPH = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] SOFT   = 3'd4;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] PERIPH_LAST = CW'(PERIPH_TO_CPU - 1);
    localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             lock_loss_count_q, lock_loss_count_d;
    logic                   periph_reset_q, periph_reset_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   seq_done_q, seq_done_d;
    logic                   hs;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rs.hard_resetn};
    assign hs     = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        lock_loss_count_d = lock_loss_count_q;
        // Losing the qualifier outranks soft requests and counter completion.
        if (state_q != HOLD && !hs) begin
            state_d = HOLD;
            cnt_d   = '0;
            if ((state_q == RUN || state_q == SOFT) && lock_loss_count_q != 8'hFF)
                lock_loss_count_d = lock_loss_count_q + 8'd1;
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_d = '0;
                    if (hs) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d = PERIPH;
                        end else begin
                            state_d = STABLE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PERIPH: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (rs.soft_reset_req) begin
                        state_d = SOFT;
                        cnt_d   = '0;
                    end
                end
                SOFT: begin
                    if (cnt_q == SOFT_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs are decoded from the next state so they move on the same edge as the state.
        periph_reset_d = (state_d == HOLD) || (state_d == STABLE);
        cpu_reset_d    = (state_d != RUN);
        seq_done_d     = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q            <= '0;
            state_q           <= HOLD;
            cnt_q             <= '0;
            lock_loss_count_q <= 8'd0;
            periph_reset_q    <= 1'b1;
            cpu_reset_q       <= 1'b1;
            seq_done_q        <= 1'b0;
        end else begin
            sync_q            <= sync_d;
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            lock_loss_count_q <= lock_loss_count_d;
            periph_reset_q    <= periph_reset_d;
            cpu_reset_q       <= cpu_reset_d;
            seq_done_q        <= seq_done_d;
        end
    end

    assign rs.periph_reset    = periph_reset_q;
    assign rs.cpu_reset       = cpu_reset_q;
    assign rs.cpu_resetn      = ~cpu_reset_q;
    assign rs.seq_done        = seq_done_q;
    assign rs.lock_loss_count = lock_loss_count_q;
    assign rs.state_dbg       = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed stimulus queues the expected output vector and the edge it
// must appear on; a monitor pops an entry every time the DUT's output vector changes.
module tb_reset_sequencer;
    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 8;
    localparam int PERIPH_TO_CPU = 4;
    localparam int SOFT_CYCLES   = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         cyc   = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [43:0] exp_q[$];
    logic [11:0] prev_vec = 12'h0;
    logic        mon_en   = 1'b0;
    logic [11:0] mon_cur;
    logic [43:0] mon_exp;

    reset_sequencer_if rif();

    reset_sequencer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .PERIPH_TO_CPU(PERIPH_TO_CPU),
        .SOFT_CYCLES  (SOFT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rs   (rif.slave)
    );

    // Clock and edge counter: at a negedge, cyc is the number of the last rising edge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mk(input logic p, input logic c, input logic d, input logic [7:0] n);
        return {p, c, ~c, d, n};
    endfunction

    function automatic logic [11:0] cur_vec();
        return {rif.periph_reset, rif.cpu_reset, rif.cpu_resetn, rif.seq_done, rif.lock_loss_count};
    endfunction

    task automatic expect_at(input int e, input logic [11:0] v);
        exp_q.push_back({32'(e), v});
    endtask

    // Land on the negedge following rising edge k; inputs set here are sampled at edge k+1.
    task automatic at(input int k);
        @(negedge clk);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: every change of the output vector must match the next queued entry, edge included.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = cur_vec();
            if (mon_cur != prev_vec) begin
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL out_change_unexpected: edge %0d got %03h (state %0d) required no change from %03h",
                             cyc, mon_cur, rif.state_dbg, prev_vec);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_exp[43:12] != 32'(cyc) || mon_exp[11:0] != mon_cur) begin
                        n_fail = n_fail + 1;
                        $display("FAIL out_change: edge %0d got %03h (state %0d) required edge %0d value %03h",
                                 cyc, mon_cur, rif.state_dbg, mon_exp[43:12], mon_exp[11:0]);
                    end
                end
                prev_vec = mon_cur;
            end
        end
    end

    initial begin
        int n;
        int g;
        int k;
        int n2;
        logic [7:0] c;

        rif.hard_resetn    = 1'b0;
        rif.soft_reset_req = 1'b0;

        // Reset held for edges 1..3.
        at(3);
        n_checks = n_checks + 1;
        if (cur_vec() != mk(1'b1, 1'b1, 1'b0, 8'd0)) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_values: got %03h required %03h", cur_vec(), mk(1'b1, 1'b1, 1'b0, 8'd0));
        end
        prev_vec = mk(1'b1, 1'b1, 1'b0, 8'd0);
        mon_en   = 1'b1;
        reset    = 1'b0;

        // Power-up with a one-cycle glitch while STABLE holds cnt=5: full wait restarts.
        at(4);
        rif.hard_resetn = 1'b1;
        n = 5;
        expect_at(n + 15, mk(1'b0, 1'b1, 1'b0, 8'd0));
        expect_at(n + 19, mk(1'b0, 1'b0, 1'b1, 8'd0));
        at(n + 4);
        rif.hard_resetn = 1'b0;
        at(n + 5);
        rif.hard_resetn = 1'b1;

        // Lock loss in RUN.
        at(30);
        rif.hard_resetn = 1'b0;
        g = 31;
        expect_at(g + 2, mk(1'b1, 1'b1, 1'b0, 8'd1));

        // Relock replays power-up timing; a soft request during PERIPH is ignored.
        at(40);
        rif.hard_resetn = 1'b1;
        n = 41;
        expect_at(n + 9, mk(1'b0, 1'b1, 1'b0, 8'd1));
        expect_at(n + 13, mk(1'b0, 1'b0, 1'b1, 8'd1));
        at(51);
        rif.soft_reset_req = 1'b1;
        at(52);
        rif.soft_reset_req = 1'b0;

        // Soft reset: 5-cycle CPU pulse, second request inside SOFT ignored.
        at(60);
        rif.soft_reset_req = 1'b1;
        expect_at(61, mk(1'b0, 1'b1, 1'b0, 8'd1));
        expect_at(66, mk(1'b0, 1'b0, 1'b1, 8'd1));
        at(61);
        rif.soft_reset_req = 1'b0;
        at(63);
        rif.soft_reset_req = 1'b1;
        at(64);
        rif.soft_reset_req = 1'b0;

        // Soft request on the same edge the lock loss is seen: HOLD wins.
        at(70);
        rif.hard_resetn = 1'b0;
        expect_at(73, mk(1'b1, 1'b1, 1'b0, 8'd2));
        at(72);
        rif.soft_reset_req = 1'b1;
        at(73);
        rif.soft_reset_req = 1'b0;

        // 258 more lock losses from RUN: 260 in total, count saturates at 255.
        c = 8'd2;
        k = 76;
        for (int i = 0; i < 258; i++) begin
            at(k);
            rif.hard_resetn = 1'b1;
            n = k + 1;
            expect_at(n + 9, mk(1'b0, 1'b1, 1'b0, c));
            expect_at(n + 13, mk(1'b0, 1'b0, 1'b1, c));
            at(n + 14);
            rif.hard_resetn = 1'b0;
            g = n + 15;
            if (c != 8'hFF) c = c + 8'd1;
            expect_at(g + 2, mk(1'b1, 1'b1, 1'b0, c));
            k = g + 3;
        end

        // Reset asserted while in PERIPH: everything back to reset values next edge.
        at(k);
        rif.hard_resetn = 1'b1;
        n = k + 1;
        expect_at(n + 9, mk(1'b0, 1'b1, 1'b0, 8'd255));
        at(n + 10);
        reset = 1'b1;
        rif.hard_resetn = 1'b0;
        expect_at(n + 11, mk(1'b1, 1'b1, 1'b0, 8'd0));
        at(n + 13);
        reset = 1'b0;

        // Power-up after reset: periph at N+9, CPU and seq_done at N+13.
        at(n + 15);
        rif.hard_resetn = 1'b1;
        n2 = n + 16;
        expect_at(n2 + 9, mk(1'b0, 1'b1, 1'b0, 8'd0));
        expect_at(n2 + 13, mk(1'b0, 1'b0, 1'b1, 8'd0));
        at(n2 + 20);

        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL missing_changes: %0d expected output changes never seen, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the combined clock/memory-ready qualifier `hard_resetn` and produces the ordered reset set for the rest of the system.
- `hard_resetn` is the AND of the video MMCM lock, the MIG MMCM lock and MIG calibration-complete.
- Synchronises `hard_resetn` into the system clock domain and requires it to be stable before releasing anything.
- Releases peripheral reset first, then CPU reset; handles lock loss and software-requested CPU-only resets.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `hard_resetn` synchroniser (min 2).
- STABLE_CYCLES, 1024, consecutive synchronised-high cycles required before peripheral release (min 1).
- PERIPH_TO_CPU, 16, cycles between peripheral release and CPU release (min 1).
- SOFT_CYCLES, 32, CPU reset pulse width for a soft reset (min 1).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- hard_resetn, input, 1, lock/calibration qualifier; asynchronous to clk, active-low.
- soft_reset_req, input, 1, single-cycle request for a CPU-only reset.
- periph_reset, output, 1, active-high peripheral/bus reset.
- cpu_reset, output, 1, active-high CPU reset.
- cpu_resetn, output, 1, always the inverse of cpu_reset.
- seq_done, output, 1, high only in RUN.
- lock_loss_count, output, 8, saturating count of lock losses seen after the first completed sequence.

Behaviour:
- Reset values while reset=1:
  - state HOLD, periph_reset=1, cpu_reset=1, cpu_resetn=0, seq_done=0, lock_loss_count=0.
  - All counters 0; synchroniser flops cleared to 0.
- Synchroniser:
  - `hs` is the output of a SYNC_STAGES flop chain.
  - A change on hard_resetn is visible on hs after exactly SYNC_STAGES edges.
- All outputs are registered; every transition below updates outputs on the same edge as the state change.
- States:
  - HOLD: all resets asserted, counter cleared. If hs=1, go to STABLE with cnt=1.
  - STABLE: while hs=1, cnt increments. On the edge where cnt==STABLE_CYCLES-1 and hs=1, go to PERIPH and deassert periph_reset. For STABLE_CYCLES=1, go directly from HOLD to PERIPH on the first hs=1 edge. Net effect: periph_reset falls on the edge at which hs has been sampled high for STABLE_CYCLES consecutive cycles.
  - PERIPH: periph_reset=0, cpu_reset=1. Counts PERIPH_TO_CPU cycles, then on the PERIPH_TO_CPU-th edge goes to RUN with cpu_reset=0 and seq_done=1.
  - RUN: all resets deasserted. soft_reset_req=1 goes to SOFT with cpu_reset=1 and seq_done=0.
  - SOFT: cpu_reset=1 for exactly SOFT_CYCLES cycles, periph_reset stays 0, then back to RUN. soft_reset_req is ignored in every state other than RUN, including while in SOFT (no retrigger or extension).
- Lock loss (hs=0) in any state other than HOLD:
  - Next edge goes to HOLD and asserts periph_reset and cpu_reset; seq_done=0. This has priority over soft_reset_req and over any counter completion on the same edge.
  - If the state was RUN or SOFT, lock_loss_count increments, saturating at 255.
- Glitch: an hs low pulse of one cycle during STABLE restarts the full STABLE_CYCLES wait.
- reset asserted mid-sequence: returns to reset values on the next edge; reset takes priority over everything.
- The count width is derived internally as clog2 of the largest parameter plus 1; no wrap is possible.

Test Plan:
- T1 power-up, STABLE_CYCLES=8, PERIPH_TO_CPU=4, SYNC_STAGES=2:
  - Stimulus: reset for 3 cycles, then hard_resetn rises at edge N.
  - Response: hs high at N+2; periph_reset falls at N+9; cpu_reset falls and seq_done rises at N+13.
- T2 glitch: hard_resetn drops for 1 cycle while in STABLE at cnt=5 -> periph_reset stays 1; release occurs 8 hs-high cycles after the glitch clears; lock_loss_count stays 0.
- T3 lock loss in RUN: hard_resetn falls -> 2 edges later hs=0; 1 edge later periph_reset=1, cpu_reset=1, seq_done=0, lock_loss_count=1. Re-locking replays the T1 timing.
- T4 soft reset, SOFT_CYCLES=5: 1-cycle soft_reset_req in RUN -> cpu_reset high for exactly 5 cycles, periph_reset stays 0, seq_done returns to 1. A second request during SOFT is ignored; the pulse stays 5 cycles.
- T5 simultaneous: soft_reset_req and hs falling on the same cycle in RUN -> HOLD (not SOFT), lock_loss_count increments by 1.
- T6 saturation and reset: 260 lock losses from RUN -> lock_loss_count=255. Asserting reset during PERIPH returns all outputs to reset values on the next edge and clears the count to 0.
